// File: rtl/ap_job_sequencer.sv
// ap_job_sequencer
// Runs one associative-processing job on the AP array. It loads operands into
// col_a and then col_b, issues the AP command, waits for ap_state_irq (with a
// timeout), and streams the result rows back out. This block drives every AP
// control input.
//
// Ports
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   job_valid_i / job_ready_o     job request handshake; ready only while idle
//   job_cmd_i, job_len_i          AP command and row count (0..ROWS, larger values saturate)
//   in_valid_i/in_ready_o/in_data_i     operand stream (A rows, then B rows)
//   out_valid_o/out_ready_i/out_data_o  result stream (one word per row)
//   done_o, err_tmo_o             1-cycle pulses: normal finish / timeout abort
//   ap_mode_o, ap_cmd_o, ap_sel_col_o, ap_write_en_o, ap_data_o, ap_addr_o  AP controls
//   ap_data_out_i                 AP read data, valid one cycle after the read address
//   ap_state_irq_i                AP operation complete
module ap_job_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CMD_W   = 3,
  parameter int RES_COL = 1,
  parameter int TMO     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [CMD_W-1:0]  job_cmd_i,
  input  logic [ADDR_W:0]   job_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              done_o,
  output logic              err_tmo_o,
  output logic              ap_mode_o,
  output logic [CMD_W-1:0]  ap_cmd_o,
  output logic              ap_sel_col_o,
  output logic              ap_write_en_o,
  output logic [DATA_W-1:0] ap_data_o,
  output logic [ADDR_W-1:0] ap_addr_o,
  input  logic [DATA_W-1:0] ap_data_out_i,
  input  logic              ap_state_irq_i
);

  localparam logic [ADDR_W:0] ROWS     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam int              TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(TMO - 1);
  localparam logic            SEL_RES  = (RES_COL != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_WAIT,
    S_RD_ISSUE, S_RD_CAPT, S_RD_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   row_q, row_d;      // one bit wider than the address so len=ROWS ends cleanly
  logic [ADDR_W:0]   len_q, len_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W:0]   row_inc;

  assign row_inc    = row_q + ONE;
  assign out_data_o = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      len_q      <= '0;
      cmd_q      <= '0;
      tmr_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      tmr_q      <= tmr_d;
      out_data_q <= out_data_d;
    end
  end

  // All outputs except out_data decode from the state, so an asynchronous
  // reset drops every AP control in the same instant.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    len_d         = len_q;
    cmd_d         = cmd_q;
    tmr_d         = tmr_q;
    out_data_d    = out_data_q;
    job_ready_o   = 1'b0;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    done_o        = 1'b0;
    err_tmo_o     = 1'b0;
    ap_mode_o     = 1'b0;
    ap_cmd_o      = '0;
    ap_sel_col_o  = 1'b0;
    ap_write_en_o = 1'b0;
    ap_data_o     = '0;
    ap_addr_o     = '0;

    unique case (state_q)
      S_IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) begin
          len_d   = (job_len_i > ROWS) ? ROWS : job_len_i;
          cmd_d   = job_cmd_i;
          row_d   = '0;
          // An empty job skips the AP entirely.
          state_d = (job_len_i == '0) ? S_DONE : S_LOAD_A;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        in_ready_o   = 1'b1;
        ap_sel_col_o = (state_q == S_LOAD_B);
        ap_addr_o    = row_q[ADDR_W-1:0];
        if (in_valid_i) begin
          ap_write_en_o = 1'b1;
          ap_data_o     = in_data_i;
          if (row_inc == len_q) begin
            row_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_RUN;
          end else begin
            row_d = row_inc;
          end
        end
      end

      S_RUN: begin
        ap_mode_o = 1'b1;
        ap_cmd_o  = cmd_q;
        tmr_d     = '0;
        state_d   = S_WAIT;
      end

      // irq is only looked at from here on; an irq seen during RUN is stale.
      S_WAIT: begin
        ap_mode_o = 1'b1;
        ap_cmd_o  = cmd_q;
        if (ap_state_irq_i) begin
          row_d   = '0;
          state_d = S_RD_ISSUE;
        end else if (tmr_q == TMR_LAST) begin
          err_tmo_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_RD_ISSUE: begin
        ap_addr_o    = row_q[ADDR_W-1:0];
        ap_sel_col_o = SEL_RES;
        state_d      = S_RD_CAPT;
      end

      S_RD_CAPT: begin
        out_data_d = ap_data_out_i;
        state_d    = S_RD_OUT;
      end

      S_RD_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (row_inc == len_q) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_inc;
            state_d = S_RD_ISSUE;
          end
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
